// File: rtl/npu_pkg.sv
// Shared NPU constants, FSM states and saturation limits.
// Ports: none (package).
package npu_pkg;

  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_BIT_DEPTH   = 8;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_DEPTH       = 26;
  localparam int DEF_SHIFT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rq_state_e;

  function automatic int sat_hi(input int bd);
    return (1 << (bd - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int bd);
    return -(1 << (bd - 1));
  endfunction

  localparam int SAT_MAX = sat_hi(DEF_BIT_DEPTH);
  localparam int SAT_MIN = sat_lo(DEF_BIT_DEPTH);

endpackage

// File: rtl/rq_sat_round.sv
// Stateless ReLU + rounding right shift (acc -> r) and saturation
// (r_in -> sat). Ports: acc/relu_en/shift_amt in, r out; r_in in, sat out.
module rq_sat_round
  import npu_pkg::*;
#(
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int BIT_DEPTH   = DEF_BIT_DEPTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic                          relu_en,
  input  logic        [SHIFT_WIDTH-1:0] shift_amt,
  output logic signed [ACC_WIDTH:0]     r,
  input  logic signed [ACC_WIDTH:0]     r_in,
  output logic signed [BIT_DEPTH-1:0]   sat
);

  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] HI = RW'(sat_hi(BIT_DEPTH));
  localparam logic signed [RW-1:0] LO = RW'(sat_lo(BIT_DEPTH));

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] sum;
  logic                 big;
  logic                 neg;

  assign neg = acc[ACC_WIDTH-1];
  assign ext = {neg, acc};

  // Shifts of ACC_WIDTH or more collapse to the sign, independent
  // of the rounding term.
  if ((1 << SHIFT_WIDTH) > ACC_WIDTH) begin : g_big
    assign big = shift_amt >= SHIFT_WIDTH'(ACC_WIDTH);
  end else begin : g_nobig
    assign big = 1'b0;
  end

  always_comb begin
    rnd = '0;
    if (shift_amt != '0 && !big)
      rnd = RW'(1) << (shift_amt - 1'b1);
  end

  // Extra bit keeps the rounding add from overflowing.
  assign sum = ext + rnd;

  always_comb begin
    r = sum >>> shift_amt;
    if (relu_en && neg)
      r = '0;
    else if (big)
      r = {RW{neg}};
  end

  always_comb begin
    sat = r_in[BIT_DEPTH-1:0];
    if (r_in > HI)
      sat = HI[BIT_DEPTH-1:0];
    else if (r_in < LO)
      sat = LO[BIT_DEPTH-1:0];
  end

endmodule

// File: rtl/res_quantizer.sv
// Requantizer: accepts accumulator tiles, quantizes, writes the buffer.
// Ports: start/relu_en/shift_amt, acc_* handshake, wr_* port, busy, done.
module res_quantizer
  import npu_pkg::*;
#(
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int BIT_DEPTH   = DEF_BIT_DEPTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic [SHIFT_WIDTH-1:0] shift_amt,
  input  logic [ACC_WIDTH-1:0]   acc_in,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  output logic [BIT_DEPTH-1:0]   wr_data,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   done
);

  // One extra bit so the write counter can hold DEPTH itself.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  rq_state_e state;
  rq_state_e state_nx;

  logic                          relu_q;
  logic        [SHIFT_WIDTH-1:0] shift_q;
  logic        [CW-1:0]          acc_cnt;
  logic        [CW-1:0]          wr_cnt;
  logic                          xfer;
  logic                          launch;
  logic                          s1_vld;
  logic signed [ACC_WIDTH:0]     s1_r;
  logic signed [ACC_WIDTH:0]     r_nx;
  logic signed [BIT_DEPTH-1:0]   sat;

  assign acc_ready = (state == RUN) && (acc_cnt < DEPTH_C);
  assign xfer      = acc_valid && acc_ready;
  assign launch    = (state == IDLE) && start;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign wr_addr   = wr_cnt[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:
        if (wr_en && wr_cnt == DEPTH_C - 1'b1)
          state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      relu_q  <= 1'b0;
      shift_q <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (launch) begin
      relu_q  <= relu_en;
      shift_q <= shift_amt;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (xfer)
        acc_cnt <= acc_cnt + 1'b1;
      if (wr_en)
        wr_cnt <= wr_cnt + 1'b1;
    end
  end

  rq_sat_round #(
    .ACC_WIDTH  (ACC_WIDTH),
    .BIT_DEPTH  (BIT_DEPTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_sr (
    .acc      ($signed(acc_in)),
    .relu_en  (relu_q),
    .shift_amt(shift_q),
    .r        (r_nx),
    .r_in     (s1_r),
    .sat      (sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_r    <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      s1_vld <= xfer;
      wr_en  <= s1_vld;
      if (xfer)
        s1_r <= r_nx;
      if (s1_vld)
        wr_data <= sat;
    end
  end

endmodule

// File: tb/tb_res_quantizer.sv
// Randomized bench for res_quantizer against a cycle-tagged reference.
// Ports: none (top-level bench).
module tb_res_quantizer;

  localparam int AW = 32;
  localparam int BD = 8;
  localparam int ADW = 10;
  localparam int DEPTH = 26;
  localparam int SW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic          relu_en;
  logic [SW-1:0] shift_amt;
  logic [AW-1:0] acc_in;
  logic          acc_valid;
  logic          acc_ready;
  logic [BD-1:0] wr_data;
  logic [ADW-1:0] wr_addr;
  logic          wr_en;
  logic          busy;
  logic          done;

  res_quantizer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .relu_en  (relu_en),
    .shift_amt(shift_amt),
    .acc_in   (acc_in),
    .acc_valid(acc_valid),
    .acc_ready(acc_ready),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: ReLU, round-half-up shift, clamp to signed BD bits.
  function automatic longint ref_q(input longint a, input bit relu,
                                   input int sh);
    longint r;
    if (relu && a < 0) return 0;
    if (sh >= AW) begin
      r = (a < 0) ? -1 : 0;
    end else begin
      r = a + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0);
      r = r >>> sh;
    end
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  typedef struct {
    longint val;
    int     due;
  } ent_t;

  ent_t   q[$];
  int     cyc;
  bit     m_run;
  int     m_acc;
  int     m_wr;
  int     done_cyc;
  longint last_d;
  bit     m_relu;
  int     m_sh;

  initial begin
    cyc = 0;
    m_run = 0;
    m_acc = 0;
    m_wr = 0;
    done_cyc = -10;
    last_d = 0;
    m_relu = 0;
    m_sh = 0;
  end

  // Outputs after edge cyc are checked here; inputs held now are
  // the ones the next edge samples, so they advance the model.
  always @(negedge clk) begin
    bit   e_ready;
    bit   e_busy;
    bit   e_wen;
    ent_t e;
    if (rst) begin
      q.delete();
      m_run = 0;
      m_acc = 0;
      m_wr = 0;
      done_cyc = -10;
      last_d = 0;
    end else begin
      e_ready = m_run && (m_acc < DEPTH);
      e_busy = m_run || (done_cyc == cyc);
      check("acc_ready", acc_ready, e_ready);
      check("busy", busy, e_busy);
      check("done", done, done_cyc == cyc);
      e_wen = (q.size() > 0) && (q[0].due == cyc);
      check("wr_en", wr_en, e_wen);
      if (e_wen) begin
        e = q.pop_front();
        check("wr_data", $signed(wr_data), e.val);
        check("wr_addr", wr_addr, m_wr);
        last_d = e.val;
        m_wr++;
        if (m_wr == DEPTH) begin
          m_run = 0;
          done_cyc = cyc + 1;
        end
      end else begin
        check("wr_data_hold", $signed(wr_data), last_d);
        check("wr_addr_hold", wr_addr, m_wr);
      end
      if (start && !e_busy) begin
        m_run = 1;
        m_acc = 0;
        m_wr = 0;
        m_relu = relu_en;
        m_sh = int'(shift_amt);
      end else if (acc_valid && e_ready) begin
        e.val = ref_q(longint'($signed(acc_in)), m_relu, m_sh);
        e.due = cyc + 2;
        q.push_back(e);
        m_acc++;
      end
    end
    cyc++;
  end

  logic [AW-1:0] tv[$];

  function automatic logic [AW-1:0] rnd_val();
    int sel;
    sel = int'($urandom_range(0, 2));
    if (sel == 0)
      return AW'(int'($urandom_range(0, 600)) - 300);
    if (sel == 1)
      return AW'($urandom);
    return AW'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
  endfunction

  task automatic fill_rand();
    while (tv.size() < DEPTH) tv.push_back(rnd_val());
  endtask

  // mode: 0 valid held, 1 valid alternates, 2 random valid.
  task automatic run_tile(input bit relu, input int sh, input int mode,
                          input int stop_at, input int start_at);
    int idx;
    int guard;
    int g;
    bit ph;
    bit v;
    bit take;
    @(posedge clk); #1;
    start = 1'b1;
    relu_en = relu;
    shift_amt = SW'(sh);
    @(posedge clk); #1;
    start = 1'b0;
    relu_en = 1'($urandom);
    shift_amt = SW'($urandom);
    idx = 0;
    guard = 0;
    ph = 1'b1;
    while (idx < DEPTH && idx != stop_at && guard < 400) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) begin
        v = ph;
        ph = !ph;
      end else v = 1'($urandom);
      acc_valid = v;
      acc_in = tv[idx];
      start = (idx == start_at);
      take = v && acc_ready;
      @(posedge clk); #1;
      if (take) idx++;
      guard++;
    end
    acc_valid = 1'b0;
    start = 1'b0;
    if (stop_at < 0) begin
      check("xfer_budget", idx, DEPTH);
      g = 0;
      while (busy && g < 40) begin
        @(posedge clk); #1;
        g++;
      end
      check("tile_end", busy, 0);
    end
  endtask

  task automatic chk_zero();
    check("rst_acc_ready", acc_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    start = 1'b0;
    relu_en = 1'b0;
    shift_amt = '0;
    acc_in = '0;
    acc_valid = 1'b0;
    #1 rst = 1'b1;
    #2 chk_zero();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    tv.delete();
    for (int i = 0; i < DEPTH; i++) tv.push_back(AW'(16 * i));
    run_tile(1'b0, 4, 0, -1, -1);

    tv.delete();
    tv.push_back(AW'(6));
    tv.push_back(AW'(5));
    tv.push_back(AW'(-6));
    tv.push_back(AW'(100000));
    tv.push_back(AW'(-100000));
    fill_rand();
    run_tile(1'b0, 2, 0, -1, -1);

    tv.delete();
    tv.push_back(AW'(-5));
    tv.push_back(AW'(0));
    tv.push_back(AW'(300));
    fill_rand();
    run_tile(1'b1, 0, 0, -1, -1);

    tv.delete();
    fill_rand();
    run_tile(1'b0, int'($urandom_range(0, 8)), 1, -1, -1);

    acc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      acc_in = rnd_val();
      @(posedge clk); #1;
    end
    acc_valid = 1'b0;

    tv.delete();
    fill_rand();
    run_tile(1'b1, 3, 2, -1, 5);

    tv.delete();
    fill_rand();
    run_tile(1'b0, 1, 0, 10, -1);
    #1 rst = 1'b1;
    #1 chk_zero();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    tv.delete();
    fill_rand();
    run_tile(1'b0, 3, 0, -1, -1);

    for (int t = 0; t < 5; t++) begin
      tv.delete();
      fill_rand();
      run_tile(1'($urandom),
               (t == 0) ? 31 : int'($urandom_range(0, 31)),
               2, -1, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/res_quantizer.md
Name: res_quantizer

Overview:
- Requantization stage directly upstream of the result buffer (res_buffer1).
- Accepts signed accumulator results from the MAC array over a valid/ready handshake, then applies optional ReLU, rounding right-shift and saturation to BIT_DEPTH.
- Drives the result buffer write port (data, address, write enable) with sequential addresses 0..DEPTH-1 and pulses done after one full tile.

Parameters:
- ACC_WIDTH, 32, signed accumulator width from the MAC array.
- BIT_DEPTH, 8, signed result width; matches the result buffer.
- ADDR_WIDTH, 10, result buffer address width.
- DEPTH, 26, entries per tile; must be ≤ 2^ADDR_WIDTH.
- SHIFT_WIDTH, 5, width of the shift amount.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a tile.
- relu_en  in  1  ReLU enable, sampled on start.
- shift_amt  in  SHIFT_WIDTH  right-shift amount, sampled on start.
- acc_in  in  ACC_WIDTH  signed accumulator value.
- acc_valid  in  1  acc_in is valid.
- acc_ready  out  1  block accepts acc_in this cycle.
- wr_data  out  BIT_DEPTH  quantized result to the buffer data input.
- wr_addr  out  ADDR_WIDTH  buffer write address.
- wr_en  out  1  buffer write enable.
- busy  out  1  tile in progress.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: acc_ready=0, wr_en=0, wr_data=0, wr_addr=0, busy=0, done=0. FSM goes to IDLE. Counters and pipeline valid bits clear.
- FSM states:
  - IDLE: start=1 → RUN. relu_en and shift_amt are latched, and the accept and write counters clear.
  - RUN: when write count reaches DEPTH → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- busy=1 in RUN and DONE.
- start outside IDLE is ignored.
- Handshake:
  - acc_ready = (state==RUN) && (accept_cnt < DEPTH). It is combinational from state and counter only, never from acc_valid.
  - A transfer occurs when acc_valid && acc_ready. accept_cnt increments on each transfer.
  - acc_valid while acc_ready=0 is ignored; no data is captured.
  - The result buffer never back-pressures, so the pipeline never stalls.
- Pipeline: 2 register stages. A transfer in cycle N gives wr_en=1 in cycle N+2. Back-to-back transfers give back-to-back writes.
- Stage 1 (registered):
  - If relu_en and acc_in < 0, the value becomes 0.
  - Otherwise compute r = (acc_in + round) >>> shift_amt in ACC_WIDTH+1 signed bits.
  - round = 1 << (shift_amt-1) when shift_amt > 0, else 0, giving round-half-up toward +inf.
  - The extra bit prevents overflow of the rounding add.
- Stage 2 (registered):
  - Saturate r to signed BIT_DEPTH, [-128, 127] at default width.
  - Drive wr_data and wr_en.
  - wr_addr = write counter value. The counter increments after each wr_en cycle.
- Addressing: the first write of a tile is at address 0 and the last at DEPTH-1. There is no wrap inside a tile; the next start restarts at 0.
- done asserts in the cycle after the write at DEPTH-1, i.e. the write at DEPTH-1 happens in the RUN→DONE cycle.
- wr_data holds its last value when wr_en=0. wr_addr holds its value (DEPTH after a tile) until the next start.
- Reset mid-tile: in-flight pipeline entries are discarded, no further writes occur, and done is not asserted.
- shift_amt ≥ ACC_WIDTH: the result is 0 for non-negative inputs and -1 for negative inputs before saturation. This is legal and defined.

Decomposition:
- Shared package npu_pkg holds:
  - default ACC_WIDTH, BIT_DEPTH, ADDR_WIDTH, DEPTH;
  - FSM state typedef (IDLE, RUN, DONE);
  - saturation limit constants derived from BIT_DEPTH.
- One natural sub-module: rq_sat_round, a stateless rounding shift + ReLU + saturation function. Stage registers stay in res_quantizer.

Test Plan:
- Basic tile: relu_en=0, shift_amt=4, acc_in=16·i for i=0..25, acc_valid held high → 26 writes at addresses 0..25 with wr_data=i; first wr_en two cycles after the first transfer; done one cycle after address 25; acc_ready=0 after the 26th transfer.
- Rounding and saturation: shift_amt=2 with acc_in of 6, 5, -6, 100000, -100000 → wr_data of 2, 1, -1, 127, -128.
- ReLU: relu_en=1, shift_amt=0 with acc_in of -5, 0, 300 → wr_data of 0, 0, 127.
- Gapped valid: acc_valid toggles every other cycle → 26 writes with contiguous addresses; no wr_en in gap cycles plus 2; done exactly once.
- Control: start during RUN → ignored, no counter reset; acc_valid in IDLE → acc_ready=0, no writes.
- Reset mid-tile: rst asserted after 10 transfers → all outputs 0 immediately (asynchronously); a later start gives a full tile from address 0.
